// File: rtl/lc3_mem_pkg.sv
// Shared definitions for the LC-3 memory responder: I/O map, FSM states, request payload.
package lc3_mem_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CHAR_W = 8;

    localparam logic [DATA_W-1:0] KBSR_ADDR = 16'hFE00;
    localparam logic [DATA_W-1:0] KBDR_ADDR = 16'hFE02;
    localparam logic [DATA_W-1:0] DSR_ADDR  = 16'hFE04;
    localparam logic [DATA_W-1:0] DDR_ADDR  = 16'hFE06;
    localparam logic [6:0]        IO_PAGE   = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        DEV_RAM  = 3'd0,
        DEV_KBSR = 3'd1,
        DEV_KBDR = 3'd2,
        DEV_DSR  = 3'd3,
        DEV_DDR  = 3'd4,
        DEV_NONE = 3'd5
    } dev_e;

    // Access captured when the control unit raises mio_en.
    typedef struct packed {
        logic              r_w;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    // Anything in the top 512-word page is I/O; unmapped I/O words decode to DEV_NONE.
    function automatic dev_e decode_dev(input logic [DATA_W-1:0] addr);
        dev_e dev;
        dev = DEV_NONE;
        if (addr[15:9] != IO_PAGE) begin
            dev = DEV_RAM;
        end else begin
            case (addr)
                KBSR_ADDR: dev = DEV_KBSR;
                KBDR_ADDR: dev = DEV_KBDR;
                DSR_ADDR:  dev = DEV_DSR;
                DDR_ADDR:  dev = DEV_DDR;
                default:   dev = DEV_NONE;
            endcase
        end
        return dev;
    endfunction

endpackage

// File: rtl/lc3_ram.sv
// Single-port word RAM: combinational read, write on the rising clock edge. Contents are not reset.
module lc3_ram #(
    parameter int unsigned AW = 12,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata_c
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata_c = mem_q[addr];

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory-side responder: wait-state FSM, RAM plus keyboard/display registers, one-cycle ready.
module lc3_mem_ctrl
    import lc3_mem_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 3,
    parameter int unsigned MEM_AW      = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mio_en,
    input  logic              r_w,
    input  logic [DATA_W-1:0] mar,
    input  logic [DATA_W-1:0] mdr_in,
    output logic [DATA_W-1:0] mem_data,
    output logic              r,
    input  logic              kb_valid,
    input  logic [CHAR_W-1:0] kb_char,
    input  logic              disp_ready,
    output logic              disp_valid,
    output logic [CHAR_W-1:0] disp_data,
    output logic              kb_int
);

    localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    state_e            state_q,      state_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    mem_req_t          req_q,        req_d;
    logic [DATA_W-1:0] mem_data_q,   mem_data_d;
    logic              kb_ready_q,   kb_ready_d;
    logic              kb_ie_q,      kb_ie_d;
    logic [CHAR_W-1:0] kb_data_q,    kb_data_d;
    logic              disp_valid_q, disp_valid_d;
    logic [CHAR_W-1:0] disp_data_q,  disp_data_d;
    logic              kb_int_q,     kb_int_d;
    logic              r_q,          r_d;

    logic              access_c;
    logic              ram_we_c;
    logic              kbdr_clear_c;
    dev_e              dev_c;
    logic [DATA_W-1:0] ram_rdata_c;
    logic [DATA_W-1:0] rdata_c;

    lc3_ram #(
        .AW (MEM_AW),
        .DW (DATA_W)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we_c & ~rst),
        .addr    (req_q.addr[MEM_AW-1:0]),
        .wdata   (req_q.wdata),
        .rdata_c (ram_rdata_c)
    );

    assign dev_c = decode_dev(req_q.addr);

    // Read data for the latched address; I/O reads see device state before this edge's updates.
    always_comb begin
        rdata_c = '0;
        case (dev_c)
            DEV_RAM:  rdata_c = ram_rdata_c;
            DEV_KBSR: rdata_c = {kb_ready_q, kb_ie_q, 14'b0};
            DEV_KBDR: rdata_c = {8'h00, kb_data_q};
            DEV_DSR:  rdata_c = {disp_ready, 15'b0};
            default:  rdata_c = '0;
        endcase
    end

    // Handshake FSM and device side effects of the access completing this cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_d        = req_q;
        mem_data_d   = mem_data_q;
        kb_ready_d   = kb_ready_q;
        kb_ie_d      = kb_ie_q;
        kb_data_d    = kb_data_q;
        disp_valid_d = 1'b0;
        disp_data_d  = disp_data_q;
        access_c     = 1'b0;
        ram_we_c     = 1'b0;
        kbdr_clear_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mio_en) begin
                    req_d.r_w   = r_w;
                    req_d.addr  = mar;
                    req_d.wdata = mdr_in;
                    cnt_d       = CNT_W'(WAIT_CYCLES);
                    state_d     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!mio_en) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    access_c = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (access_c) begin
            if (req_q.r_w) begin
                case (dev_c)
                    DEV_RAM:  ram_we_c = 1'b1;
                    DEV_KBSR: kb_ie_d  = req_q.wdata[14];
                    DEV_DDR: begin
                        disp_data_d  = req_q.wdata[CHAR_W-1:0];
                        disp_valid_d = 1'b1;
                    end
                    default: ;
                endcase
            end else begin
                mem_data_d   = rdata_c;
                kbdr_clear_c = (dev_c == DEV_KBDR);
            end
        end

        // A character arriving on the same edge as a KBDR read survives the read's clear.
        if (kb_valid && (!kb_ready_q || kbdr_clear_c)) begin
            kb_data_d  = kb_char;
            kb_ready_d = 1'b1;
        end else if (kbdr_clear_c) begin
            kb_ready_d = 1'b0;
        end

        kb_int_d = kb_ready_d & kb_ie_d;
        r_d      = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            req_q        <= '0;
            mem_data_q   <= '0;
            kb_ready_q   <= 1'b0;
            kb_ie_q      <= 1'b0;
            kb_data_q    <= '0;
            disp_valid_q <= 1'b0;
            disp_data_q  <= '0;
            kb_int_q     <= 1'b0;
            r_q          <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            mem_data_q   <= mem_data_d;
            kb_ready_q   <= kb_ready_d;
            kb_ie_q      <= kb_ie_d;
            kb_data_q    <= kb_data_d;
            disp_valid_q <= disp_valid_d;
            disp_data_q  <= disp_data_d;
            kb_int_q     <= kb_int_d;
            r_q          <= r_d;
        end
    end

    assign mem_data   = mem_data_q;
    assign r          = r_q;
    assign disp_valid = disp_valid_q;
    assign disp_data  = disp_data_q;
    assign kb_int     = kb_int_q;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Directed bench for lc3_mem_ctrl: vector table for single accesses, hand sequences for
// abort, reset, same-edge keyboard capture and zero-wait back-to-back accesses.
module tb_lc3_mem_ctrl;

    localparam int unsigned WAIT_A = 3;
    localparam int unsigned WAIT_B = 0;
    localparam int          NVEC   = 26;

    logic        clk = 1'b0;
    logic        rst;
    logic        mio_en, mio_en0;
    logic        r_w;
    logic [15:0] mar, mdr_in;
    logic        kb_valid;
    logic [7:0]  kb_char;
    logic        disp_ready;
    logic        zero_bit;
    logic [7:0]  zero_char;

    logic [15:0] mem_data, mem_data0;
    logic        r, r0;
    logic        disp_valid, disp_valid0;
    logic [7:0]  disp_data, disp_data0;
    logic        kb_int, kb_int0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lc3_mem_ctrl #(.WAIT_CYCLES(WAIT_A), .MEM_AW(12)) dut (
        .clk        (clk),
        .rst        (rst),
        .mio_en     (mio_en),
        .r_w        (r_w),
        .mar        (mar),
        .mdr_in     (mdr_in),
        .mem_data   (mem_data),
        .r          (r),
        .kb_valid   (kb_valid),
        .kb_char    (kb_char),
        .disp_ready (disp_ready),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .kb_int     (kb_int)
    );

    lc3_mem_ctrl #(.WAIT_CYCLES(WAIT_B), .MEM_AW(12)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .mio_en     (mio_en0),
        .r_w        (r_w),
        .mar        (mar),
        .mdr_in     (mdr_in),
        .mem_data   (mem_data0),
        .r          (r0),
        .kb_valid   (zero_bit),
        .kb_char    (zero_char),
        .disp_ready (zero_bit),
        .disp_valid (disp_valid0),
        .disp_data  (disp_data0),
        .kb_int     (kb_int0)
    );

    typedef struct {
        bit          is_kb;
        logic        w;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [7:0]  kch;
        logic        drdy;
        logic [15:0] exp_q;
        logic        exp_int;
        logic        exp_dv;
        logic [7:0]  exp_dd;
    } vec_t;

    vec_t vt [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic kb_pulse(input logic [7:0] c);
        kb_valid = 1'b1;
        kb_char  = c;
        tick();
        kb_valid = 1'b0;
    endtask

    // One handshake; lat counts edges from the one that samples mio_en to the one raising r,
    // so lat = WAIT_CYCLES + 2. Optionally pulses kb_valid onto the access edge itself.
    task automatic access(input bit sel, input logic w, input logic [15:0] a, input logic [15:0] d,
                          input bit kb_late, input logic [7:0] kch,
                          output logic [15:0] q, output int lat, output logic dv,
                          output logic [7:0] dd, output logic ki);
        int wt;
        logic rr;
        wt     = sel ? int'(WAIT_B) : int'(WAIT_A);
        r_w    = w;
        mar    = a;
        mdr_in = d;
        if (sel) mio_en0 = 1'b1;
        else     mio_en  = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
            if (kb_late && lat == wt + 1) begin
                kb_valid = 1'b1;
                kb_char  = kch;
            end else begin
                kb_valid = 1'b0;
            end
            rr = sel ? r0 : r;
        end while (!rr && lat < 40);
        kb_valid = 1'b0;
        q  = sel ? mem_data0 : mem_data;
        dv = sel ? disp_valid0 : disp_valid;
        dd = sel ? disp_data0 : disp_data;
        ki = kb_int;
        mio_en  = 1'b0;
        mio_en0 = 1'b0;
        tick();
        chk($sformatf("r_one_cycle_%h", a), 32'(sel ? r0 : r), 32'(0));
        chk($sformatf("dv_one_cycle_%h", a), 32'(sel ? disp_valid0 : disp_valid), 32'(0));
    endtask

    initial begin
        logic [15:0] q;
        int          lat;
        logic        dv, ki;
        logic [7:0]  dd;

        //           kb  w     addr      wdata     kch    drdy  exp_q     int   dv    dd
        vt[0]  = '{0, 1'b1, 16'h3000, 16'h1234, 8'h00, 1'b1, 16'h0000, 1'b0, 1'b0, 8'h00};
        vt[1]  = '{0, 1'b0, 16'h3000, 16'h0000, 8'h00, 1'b1, 16'h1234, 1'b0, 1'b0, 8'h00};
        vt[2]  = '{0, 1'b1, 16'h3001, 16'h1111, 8'h00, 1'b1, 16'h1234, 1'b0, 1'b0, 8'h00};
        vt[3]  = '{0, 1'b0, 16'h3001, 16'h0000, 8'h00, 1'b1, 16'h1111, 1'b0, 1'b0, 8'h00};
        vt[4]  = '{0, 1'b0, 16'hF000, 16'h0000, 8'h00, 1'b1, 16'h1234, 1'b0, 1'b0, 8'h00};
        vt[5]  = '{1, 1'b0, 16'h0000, 16'h0000, 8'h41, 1'b1, 16'h0000, 1'b0, 1'b0, 8'h00};
        vt[6]  = '{0, 1'b0, 16'hFE00, 16'h0000, 8'h00, 1'b1, 16'h8000, 1'b0, 1'b0, 8'h00};
        vt[7]  = '{0, 1'b0, 16'hFE02, 16'h0000, 8'h00, 1'b1, 16'h0041, 1'b0, 1'b0, 8'h00};
        vt[8]  = '{0, 1'b0, 16'hFE00, 16'h0000, 8'h00, 1'b1, 16'h0000, 1'b0, 1'b0, 8'h00};
        vt[9]  = '{0, 1'b1, 16'hFE00, 16'h4000, 8'h00, 1'b1, 16'h0000, 1'b0, 1'b0, 8'h00};
        vt[10] = '{1, 1'b0, 16'h0000, 16'h0000, 8'h41, 1'b1, 16'h0000, 1'b1, 1'b0, 8'h00};
        vt[11] = '{1, 1'b0, 16'h0000, 16'h0000, 8'h42, 1'b1, 16'h0000, 1'b1, 1'b0, 8'h00};
        vt[12] = '{0, 1'b0, 16'hFE00, 16'h0000, 8'h00, 1'b1, 16'hC000, 1'b1, 1'b0, 8'h00};
        vt[13] = '{0, 1'b0, 16'hFE02, 16'h0000, 8'h00, 1'b1, 16'h0041, 1'b0, 1'b0, 8'h00};
        vt[14] = '{0, 1'b1, 16'hFE06, 16'h0058, 8'h00, 1'b1, 16'h0041, 1'b0, 1'b1, 8'h58};
        vt[15] = '{0, 1'b0, 16'hFE04, 16'h0000, 8'h00, 1'b1, 16'h8000, 1'b0, 1'b0, 8'h58};
        vt[16] = '{0, 1'b0, 16'hFE04, 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h58};
        vt[17] = '{0, 1'b1, 16'hFE06, 16'h0159, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h59};
        vt[18] = '{0, 1'b0, 16'h3000, 16'h0000, 8'h00, 1'b1, 16'h1234, 1'b0, 1'b0, 8'h59};
        vt[19] = '{0, 1'b0, 16'hFE06, 16'h0000, 8'h00, 1'b1, 16'h0000, 1'b0, 1'b0, 8'h59};
        vt[20] = '{0, 1'b0, 16'h3001, 16'h0000, 8'h00, 1'b1, 16'h1111, 1'b0, 1'b0, 8'h59};
        vt[21] = '{0, 1'b0, 16'hFE08, 16'h0000, 8'h00, 1'b1, 16'h0000, 1'b0, 1'b0, 8'h59};
        vt[22] = '{0, 1'b1, 16'hFE02, 16'h00FF, 8'h00, 1'b1, 16'h0000, 1'b0, 1'b0, 8'h59};
        vt[23] = '{0, 1'b0, 16'hFE02, 16'h0000, 8'h00, 1'b1, 16'h0041, 1'b0, 1'b0, 8'h59};
        vt[24] = '{0, 1'b0, 16'hFE00, 16'h0000, 8'h00, 1'b1, 16'h4000, 1'b0, 1'b0, 8'h59};
        vt[25] = '{0, 1'b0, 16'h3001, 16'h0000, 8'h00, 1'b1, 16'h1111, 1'b0, 1'b0, 8'h59};

        rst = 1'b1; mio_en = 1'b0; mio_en0 = 1'b0; r_w = 1'b0; mar = '0; mdr_in = '0;
        kb_valid = 1'b0; kb_char = '0; disp_ready = 1'b1; zero_bit = 1'b0; zero_char = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        chk("rst_r", 32'(r), 32'(0));
        chk("rst_mem_data", 32'(mem_data), 32'(0));
        chk("rst_disp_valid", 32'(disp_valid), 32'(0));
        chk("rst_disp_data", 32'(disp_data), 32'(0));
        chk("rst_kb_int", 32'(kb_int), 32'(0));
        chk("rst_r0", 32'(r0), 32'(0));
        chk("rst_mem_data0", 32'(mem_data0), 32'(0));

        for (int i = 0; i < NVEC; i++) begin
            disp_ready = vt[i].drdy;
            if (vt[i].is_kb) begin
                kb_pulse(vt[i].kch);
                chk($sformatf("vec%0d_kb_int", i), 32'(kb_int), 32'(vt[i].exp_int));
            end else begin
                access(1'b0, vt[i].w, vt[i].addr, vt[i].wdata, 1'b0, 8'h00, q, lat, dv, dd, ki);
                chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(WAIT_A + 2));
                chk($sformatf("vec%0d_mem_data", i), 32'(q), 32'(vt[i].exp_q));
                chk($sformatf("vec%0d_kb_int", i), 32'(ki), 32'(vt[i].exp_int));
                chk($sformatf("vec%0d_disp_valid", i), 32'(dv), 32'(vt[i].exp_dv));
                chk($sformatf("vec%0d_disp_data", i), 32'(dd), 32'(vt[i].exp_dd));
            end
        end
        disp_ready = 1'b1;

        // Abort: drop mio_en during the wait states of a write.
        r_w = 1'b1; mar = 16'h3001; mdr_in = 16'h9999; mio_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("abort_busy_r", 32'(r), 32'(0));
        end
        mio_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort_idle_r", 32'(r), 32'(0));
        end
        access(1'b0, 1'b0, 16'h3001, 16'h0000, 1'b0, 8'h00, q, lat, dv, dd, ki);
        chk("abort_ram_kept", 32'(q), 32'h1111);
        chk("abort_latency", 32'(lat), 32'(WAIT_A + 2));

        // New character on the same edge as a KBDR read: old char returned, new one held.
        kb_pulse(8'h43);
        chk("same_edge_pre_int", 32'(kb_int), 32'(1));
        access(1'b0, 1'b0, 16'hFE02, 16'h0000, 1'b1, 8'h44, q, lat, dv, dd, ki);
        chk("same_edge_data", 32'(q), 32'h0043);
        chk("same_edge_int", 32'(ki), 32'(1));
        access(1'b0, 1'b0, 16'hFE02, 16'h0000, 1'b0, 8'h00, q, lat, dv, dd, ki);
        chk("same_edge_next", 32'(q), 32'h0044);
        chk("same_edge_next_int", 32'(ki), 32'(0));

        // Reset in the middle of a write, with a keyboard interrupt pending.
        kb_pulse(8'h55);
        chk("pre_rst_int", 32'(kb_int), 32'(1));
        r_w = 1'b1; mar = 16'h3001; mdr_in = 16'h7777; mio_en = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        mio_en = 1'b0;
        tick();
        chk("midrst_r", 32'(r), 32'(0));
        chk("midrst_mem_data", 32'(mem_data), 32'(0));
        chk("midrst_kb_int", 32'(kb_int), 32'(0));
        chk("midrst_disp_data", 32'(disp_data), 32'(0));
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("postrst_r", 32'(r), 32'(0));
        end
        access(1'b0, 1'b0, 16'h3001, 16'h0000, 1'b0, 8'h00, q, lat, dv, dd, ki);
        chk("postrst_ram_kept", 32'(q), 32'h1111);
        chk("postrst_latency", 32'(lat), 32'(WAIT_A + 2));
        access(1'b0, 1'b0, 16'hFE00, 16'h0000, 1'b0, 8'h00, q, lat, dv, dd, ki);
        chk("postrst_kbsr", 32'(q), 32'h0000);

        // Zero wait states: single accesses, then mio_en held across several accesses.
        access(1'b1, 1'b1, 16'h0005, 16'h00AB, 1'b0, 8'h00, q, lat, dv, dd, ki);
        chk("w0_write_latency", 32'(lat), 32'(WAIT_B + 2));
        access(1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 8'h00, q, lat, dv, dd, ki);
        chk("w0_read_latency", 32'(lat), 32'(WAIT_B + 2));
        chk("w0_read_data", 32'(q), 32'h00AB);
        chk("w0_main_idle_r", 32'(r), 32'(0));
        r_w = 1'b0; mar = 16'h0005; mio_en0 = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk($sformatf("b2b_r_cycle%0d", i), 32'(r0), 32'((i % 3) == 2));
            if ((i % 3) == 2) chk($sformatf("b2b_data_cycle%0d", i), 32'(mem_data0), 32'h00AB);
        end
        mio_en0 = 1'b0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
